// File: rtl/frame_swap_ctrl.sv
// Double-buffer sequencer for the LED-matrix frame RAM: DMA fills the back bank,
// and the banks are exchanged only at a scanner frame boundary once the fill is complete.
module frame_swap_ctrl #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_start,
  input  logic             csr_auto,
  output logic             dma_start,
  input  logic             dma_done,
  input  logic             scan_frame_end,
  output logic             dma_bank,
  output logic             scan_bank,
  output logic             scan_enable,
  output logic             swap_done,
  output logic             busy,
  output logic             dma_timeout,
  output logic [CNT_W-1:0] frame_count
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_TERM = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FILL, READY, SWAP} state_t;

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_d;
  logic               csr_start_q;
  logic               start_edge;
  logic               fill_entry;
  logic               dma_start_d;
  logic               busy_d;
  logic               swap_done_d;
  logic               dma_timeout_d;
  logic               dma_bank_d;
  logic               scan_bank_d;
  logic               scan_enable_d;
  logic [CNT_W-1:0]   frame_count_d;

  // Every output is the registered form of a value precomputed by the output process.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      csr_start_q <= 1'b0;
      dma_start   <= 1'b0;
      busy        <= 1'b0;
      swap_done   <= 1'b0;
      dma_timeout <= 1'b0;
      dma_bank    <= 1'b1;
      scan_bank   <= 1'b0;
      scan_enable <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_d;
      csr_start_q <= csr_start;
      dma_start   <= dma_start_d;
      busy        <= busy_d;
      swap_done   <= swap_done_d;
      dma_timeout <= dma_timeout_d;
      dma_bank    <= dma_bank_d;
      scan_bank   <= scan_bank_d;
      scan_enable <= scan_enable_d;
      frame_count <= frame_count_d;
    end
  end

  assign start_edge = csr_start & ~csr_start_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_edge) state_next = FILL;
      // A completed fill wins over a timeout landing in the same cycle.
      FILL: begin
        if (dma_done)                 state_next = READY;
        else if (timer == TIMER_TERM) state_next = IDLE;
      end
      READY: if (!scan_enable || scan_frame_end) state_next = SWAP;
      SWAP:  state_next = csr_auto ? FILL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fill_entry    = (state_next == FILL) && (state != FILL);
    dma_start_d   = fill_entry;
    busy_d        = (state_next != IDLE);
    swap_done_d   = (state_next == SWAP);
    dma_timeout_d = dma_timeout;
    if (fill_entry && state == IDLE)
      dma_timeout_d = 1'b0;
    else if (state == FILL && state_next == IDLE)
      dma_timeout_d = 1'b1;
    timer_d = timer;
    if (fill_entry)
      timer_d = '0;
    else if (state == FILL && timer != TIMER_TERM)
      timer_d = timer + 1'b1;
    dma_bank_d    = swap_done_d ? ~dma_bank : dma_bank;
    scan_bank_d   = swap_done_d ? ~scan_bank : scan_bank;
    scan_enable_d = scan_enable | swap_done_d;
    frame_count_d = swap_done_d ? frame_count + 1'b1 : frame_count;
  end

endmodule
